// File: rtl/blockid_pkg.sv
// Shared constants and helpers for the segmented GVSP block-ID counter.
package blockid_pkg;

    localparam bit DEFAULT_INIT_BIT = 1'b1;
    localparam int MIN_SEG_WIDTH    = 4;

    function automatic int calc_nseg(input int cnt_width, input int seg_width);
        return cnt_width / seg_width;
    endfunction

    // A segment must not be able to wrap twice while its own carry is still in flight.
    function automatic bit seg_range_ok(input int cnt_width, input int seg_width);
        if (seg_width >= 31)
            return 1'b1;
        return (1 << seg_width) > calc_nseg(cnt_width, seg_width);
    endfunction

endpackage

// File: rtl/blockid_seg.sv
// One SEG_WIDTH slice of the block-ID counter.
// It has a registered carry-out that feeds the next slice one edge later.
module blockid_seg
    import blockid_pkg::*;
#(
    parameter int                   SEG_WIDTH   = 32,
    parameter logic [SEG_WIDTH-1:0] CLEAR_VALUE = '1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 load,
    input  logic [SEG_WIDTH-1:0] load_value,
    input  logic                 carry_in,
    output logic [SEG_WIDTH-1:0] seg_value,
    output logic                 carry_out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_value <= CLEAR_VALUE;
            carry_out <= 1'b0;
        end else if (clear) begin
            seg_value <= CLEAR_VALUE;
            carry_out <= 1'b0;
        end else if (load) begin
            seg_value <= load_value;
            carry_out <= 1'b0;
        end else begin
            carry_out <= carry_in && (seg_value == '1);
            if (carry_in)
                seg_value <= seg_value + 1'b1;
        end
    end

endmodule

// File: rtl/blockid_counter_seg.sv
// Parametrised block-ID counter built from NSEG slices with registered carries.
// It also provides coherence, wrap and sticky-wrap reporting.
module blockid_counter_seg
    import blockid_pkg::*;
#(
    parameter int                   CNT_WIDTH  = 64,
    parameter int                   SEG_WIDTH  = 32,
    parameter logic [CNT_WIDTH-1:0] INIT_VALUE = {CNT_WIDTH{DEFAULT_INIT_BIT}}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_stream_enable,
    input  logic                 i_fval_rise,
    input  logic                 i_load,
    input  logic [CNT_WIDTH-1:0] iv_load_value,
    output logic [CNT_WIDTH-1:0] ov_blockid,
    output logic                 o_blockid_valid,
    output logic                 o_wrap,
    output logic                 o_wrap_sticky
);

    localparam int NSEG = calc_nseg(CNT_WIDTH, SEG_WIDTH);

    if (CNT_WIDTH % SEG_WIDTH != 0) begin : g_bad_divisor
        $error("CNT_WIDTH must be a multiple of SEG_WIDTH");
    end
    if (SEG_WIDTH < MIN_SEG_WIDTH) begin : g_bad_seg_width
        $error("SEG_WIDTH is below the minimum segment width");
    end
    if (!seg_range_ok(CNT_WIDTH, SEG_WIDTH)) begin : g_bad_seg_range
        $error("2**SEG_WIDTH must exceed the segment count");
    end

    logic            stream_clear;
    logic            fresh;
    logic [NSEG-1:0] carry_in;
    logic [NSEG-1:0] carry_q;
    logic [NSEG-1:0] tag_in;
    logic [NSEG-1:0] tag_q;

    assign stream_clear = !i_stream_enable;
    assign carry_in[0]  = i_fval_rise;
    assign tag_in[0]    = fresh;

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        if (k > 0) begin : g_chain
            assign carry_in[k] = carry_q[k-1];
            assign tag_in[k]   = tag_q[k-1];
        end

        blockid_seg #(
            .SEG_WIDTH  (SEG_WIDTH),
            .CLEAR_VALUE(INIT_VALUE[k*SEG_WIDTH +: SEG_WIDTH])
        ) u_seg (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (stream_clear),
            .load      (i_load),
            .load_value(iv_load_value[k*SEG_WIDTH +: SEG_WIDTH]),
            .carry_in  (carry_in[k]),
            .seg_value (ov_blockid[k*SEG_WIDTH +: SEG_WIDTH]),
            .carry_out (carry_q[k])
        );
    end

    // Each carry pulse travels with a tag recording whether its increment started
    // while fresh was set. A tagged top carry-out is the expected INIT-to-0 rollover.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fresh         <= 1'b1;
            tag_q         <= '0;
            o_wrap_sticky <= 1'b0;
        end else if (stream_clear) begin
            fresh         <= 1'b1;
            tag_q         <= '0;
            o_wrap_sticky <= 1'b0;
        end else if (i_load) begin
            fresh         <= 1'b0;
            tag_q         <= '0;
            o_wrap_sticky <= 1'b0;
        end else begin
            tag_q <= carry_in & tag_in;
            if (i_fval_rise)
                fresh <= 1'b0;
            if (o_wrap)
                o_wrap_sticky <= 1'b1;
        end
    end

    assign o_blockid_valid = ~|carry_q;
    assign o_wrap          = carry_q[NSEG-1] & ~tag_q[NSEG-1];

endmodule

// File: tb/tb_blockid_counter_seg.sv
// Table-driven, scoreboard-checked bench for a 16/4 and a 64/32 block-ID counter.
module tb_blockid_counter_seg;

    typedef struct {
        bit          wide;
        bit          en;
        bit          fval;
        bit          ld;
        logic [63:0] ldv;
        logic [63:0] id;
        bit          valid;
        bit          wrap;
        bit          sticky;
        string       name;
    } step_t;

    typedef struct {
        logic [63:0] id;
        bit          valid;
        bit          wrap;
        bit          sticky;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        n_en, n_fval, n_ld;
    logic [15:0] n_ldv;
    logic [15:0] n_id;
    logic        n_valid, n_wrap, n_sticky;
    logic        w_en, w_fval, w_ld;
    logic [63:0] w_ldv;
    logic [63:0] w_id;
    logic        w_valid, w_wrap, w_sticky;

    exp_t  exp_q[$];
    step_t steps[$];
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    blockid_counter_seg #(.CNT_WIDTH(16), .SEG_WIDTH(4)) u_narrow (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_stream_enable(n_en),
        .i_fval_rise    (n_fval),
        .i_load         (n_ld),
        .iv_load_value  (n_ldv),
        .ov_blockid     (n_id),
        .o_blockid_valid(n_valid),
        .o_wrap         (n_wrap),
        .o_wrap_sticky  (n_sticky)
    );

    blockid_counter_seg #(.CNT_WIDTH(64), .SEG_WIDTH(32)) u_wide (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_stream_enable(w_en),
        .i_fval_rise    (w_fval),
        .i_load         (w_ld),
        .iv_load_value  (w_ldv),
        .ov_blockid     (w_id),
        .o_blockid_valid(w_valid),
        .o_wrap         (w_wrap),
        .o_wrap_sticky  (w_sticky)
    );

    function automatic step_t mk(input bit wide, input bit en, input bit fval, input bit ld,
                                 input logic [63:0] ldv, input logic [63:0] id,
                                 input bit valid, input bit wrap, input bit sticky,
                                 input string name);
        step_t s;
        s.wide = wide; s.en = en; s.fval = fval; s.ld = ld; s.ldv = ldv;
        s.id = id; s.valid = valid; s.wrap = wrap; s.sticky = sticky; s.name = name;
        return s;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pushExpect(input logic [63:0] id, input bit valid, input bit wrap,
                              input bit sticky, input string name);
        exp_t e;
        e.id = id; e.valid = valid; e.wrap = wrap; e.sticky = sticky; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input bit wide);
        exp_t        e;
        logic [63:0] aid;
        logic        av, aw, as;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e   = exp_q.pop_front();
        aid = wide ? w_id : {48'h0, n_id};
        av  = wide ? w_valid : n_valid;
        aw  = wide ? w_wrap : n_wrap;
        as  = wide ? w_sticky : n_sticky;
        cmp({e.name, ".id"},     aid,          e.id);
        cmp({e.name, ".valid"},  {63'h0, av},  {63'h0, e.valid});
        cmp({e.name, ".wrap"},   {63'h0, aw},  {63'h0, e.wrap});
        cmp({e.name, ".sticky"}, {63'h0, as},  {63'h0, e.sticky});
    endtask

    task automatic driveIdle();
        n_en = 1'b1; n_fval = 1'b0; n_ld = 1'b0; n_ldv = '0;
        w_en = 1'b1; w_fval = 1'b0; w_ld = 1'b0; w_ldv = '0;
    endtask

    task automatic applyStimulus(input step_t s);
        @(negedge clk);
        driveIdle();
        if (s.wide) begin
            w_en = s.en; w_fval = s.fval; w_ld = s.ld; w_ldv = s.ldv;
        end else begin
            n_en = s.en; n_fval = s.fval; n_ld = s.ld; n_ldv = s.ldv[15:0];
        end
        pushExpect(s.id, s.valid, s.wrap, s.sticky, s.name);
        @(posedge clk);
        #1;
        checkOutput(s.wide);
    endtask

    task automatic expectInit(input string name);
        pushExpect(64'h0000_0000_0000_FFFF, 1'b1, 1'b0, 1'b0, {name, ".narrow"});
        checkOutput(1'b0);
        pushExpect(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, {name, ".wide"});
        checkOutput(1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        driveIdle();
        repeat (2) @(posedge clk);
        #1;
        expectInit("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // wide: first pulse from INIT ripples to 0 without a wrap
        steps.push_back(mk(1,1,1,0, 64'h0, 64'hFFFF_FFFF_0000_0000, 0,0,0, "w_first"));
        steps.push_back(mk(1,1,0,0, 64'h0, 64'h0, 0,0,0, "w_first_rip"));
        steps.push_back(mk(1,1,0,0, 64'h0, 64'h0, 1,0,0, "w_first_done"));
        steps.push_back(mk(1,1,0,1, 64'h0000_0000_FFFF_FFFE, 64'h0000_0000_FFFF_FFFE, 1,0,0, "w_load"));
        steps.push_back(mk(1,1,1,0, 64'h0, 64'h0000_0000_FFFF_FFFF, 1,0,0, "w_p1"));
        steps.push_back(mk(1,1,1,0, 64'h0, 64'h0000_0000_0000_0000, 0,0,0, "w_p2"));
        steps.push_back(mk(1,1,1,0, 64'h0, 64'h0000_0001_0000_0001, 1,0,0, "w_p3"));
        steps.push_back(mk(1,1,0,0, 64'h0, 64'h0000_0001_0000_0001, 1,0,0, "w_hold"));
        // narrow: back-to-back pulses through a full rollover
        steps.push_back(mk(0,1,0,1, 64'hFFFE, 64'hFFFE, 1,0,0, "n_load"));
        steps.push_back(mk(0,1,1,0, 64'h0, 64'hFFFF, 1,0,0, "n_p1"));
        steps.push_back(mk(0,1,1,0, 64'h0, 64'hFFF0, 0,0,0, "n_p2"));
        steps.push_back(mk(0,1,1,0, 64'h0, 64'hFF01, 0,0,0, "n_p3"));
        steps.push_back(mk(0,1,0,0, 64'h0, 64'hF001, 0,0,0, "n_rip2"));
        steps.push_back(mk(0,1,0,0, 64'h0, 64'h0001, 0,1,0, "n_wrap"));
        steps.push_back(mk(0,1,0,0, 64'h0, 64'h0001, 1,0,1, "n_sticky"));
        // narrow: clear mid-ripple, inputs ignored while disabled
        steps.push_back(mk(0,1,0,1, 64'h0FFF, 64'h0FFF, 1,0,0, "n_ld0fff"));
        steps.push_back(mk(0,1,1,0, 64'h0, 64'h0FF0, 0,0,0, "n_rip_start"));
        steps.push_back(mk(0,0,1,0, 64'h0, 64'hFFFF, 1,0,0, "n_clear"));
        steps.push_back(mk(0,0,1,1, 64'h1111, 64'hFFFF, 1,0,0, "n_dis_ignore"));
        steps.push_back(mk(0,1,0,0, 64'h0, 64'hFFFF, 1,0,0, "n_reenable"));
        steps.push_back(mk(0,1,1,0, 64'h0, 64'hFFF0, 0,0,0, "n_fresh_p"));
        steps.push_back(mk(0,1,0,0, 64'h0, 64'hFF00, 0,0,0, "n_fresh_r1"));
        steps.push_back(mk(0,1,0,0, 64'h0, 64'hF000, 0,0,0, "n_fresh_r2"));
        steps.push_back(mk(0,1,0,0, 64'h0, 64'h0000, 0,0,0, "n_fresh_r3"));
        steps.push_back(mk(0,1,0,0, 64'h0, 64'h0000, 1,0,0, "n_fresh_done"));
        // narrow: load beats a coincident pulse
        steps.push_back(mk(0,1,1,1, 64'h1234, 64'h1234, 1,0,0, "n_ld_fval"));
        steps.push_back(mk(0,1,0,0, 64'h0, 64'h1234, 1,0,0, "n_ld_hold"));
        // wide: real rollover after a load
        steps.push_back(mk(1,1,0,1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1,0,0, "w_ld_ones"));
        steps.push_back(mk(1,1,1,0, 64'h0, 64'hFFFF_FFFF_0000_0000, 0,0,0, "w_roll_p"));
        steps.push_back(mk(1,1,0,0, 64'h0, 64'h0, 0,1,0, "w_wrap"));
        steps.push_back(mk(1,1,0,0, 64'h0, 64'h0, 1,0,1, "w_sticky"));

        foreach (steps[i])
            applyStimulus(steps[i]);

        // async reset between edges while the narrow counter is mid-ripple
        applyStimulus(mk(0,1,0,1, 64'h0FFF, 64'h0FFF, 1,0,0, "ar_load"));
        applyStimulus(mk(0,1,1,0, 64'h0, 64'h0FF0, 0,0,0, "ar_pulse"));
        #2;
        rst_n = 1'b0;
        driveIdle();
        #1;
        expectInit("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(mk(0,1,0,0, 64'h0, 64'hFFFF, 1,0,0, "ar_after_n"));
        applyStimulus(mk(1,1,0,0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1,0,0, "ar_after_w"));
        applyStimulus(mk(0,1,1,0, 64'h0, 64'hFFF0, 0,0,0, "ar_resume"));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
